fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the Lab7-style simple RISC CPU.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    // Default geometry of the Lab7 CPU fetch path.
    localparam int DEF_PC_W    = 8;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_MEM_LAT = 1;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        LOAD   = 3'd0,   // waiting to pick up start_pc after reset
        FETCH  = 3'd1,   // issuing the memory read for pc
        WAIT   = 3'd2,   // counting down the fixed memory latency
        HOLD   = 3'd3,   // presenting a word to the decoder
        HALTED = 3'd4    // sticky stop, left only through reset
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory read port and the decoder-facing
// valid/ready port of the fetch unit. The fetch unit takes the master
// view; the memory/decoder side takes the slave view.
interface fetch_unit_if #(
    parameter int PC_W    = fetch_pkg::DEF_PC_W,
    parameter int INSTR_W = fetch_pkg::DEF_INSTR_W
);
    // Instruction-memory read port.
    logic               mem_rd;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_rdata;

    // Decoder handshake port.
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;

    modport master (
        output mem_rd, mem_addr, instr_valid, instr, instr_pc,
        input  mem_rdata, instr_ready
    );

    modport slave (
        input  mem_rd, mem_addr, instr_valid, instr, instr_pc,
        output mem_rdata, instr_ready
    );

endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: loads start_pc after reset, reads one word
// per fetch from a fixed-latency pipelined memory, presents it to the
// decoder over valid/ready, and supports branch redirect and sticky halt.
// Within one cycle halt_req beats br_taken, which beats the handshake.
// The interface instance must be built with the same PC_W/INSTR_W.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] start_pc,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            halt_req,
    output logic            halted,
    fetch_unit_if.master    bus
);

    // Wide enough to hold MEM_LAT-1; the memory response is captured on the
    // WAIT cycle where the counter has reached zero.
    localparam int WCNT_W = $clog2(MEM_LAT + 1);
    localparam logic [WCNT_W-1:0] WCNT_START = WCNT_W'(MEM_LAT - 1);

    fetch_state_e       state_q,       state_d;
    logic [PC_W-1:0]    pc_q,          pc_d;
    logic [WCNT_W-1:0]  wcnt_q,        wcnt_d;
    logic [INSTR_W-1:0] instr_q,       instr_d;
    logic [PC_W-1:0]    instr_pc_q,    instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q,      halted_d;

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        // NOTE: every _d starts at its held value so no path through the
        // case below leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        wcnt_d        = wcnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;

        unique case (state_q)
            LOAD: begin
                // Control requests are not yet meaningful; just pick up the
                // first fetch address.
                pc_d    = start_pc;
                state_d = FETCH;
            end

            FETCH, WAIT, HOLD: begin
                if (halt_req) begin
                    state_d       = HALTED;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else if (br_taken) begin
                    // Any in-flight response is dropped implicitly: the new
                    // FETCH restarts the latency count, so the old word's
                    // arrival cycle never lines up with a capture.
                    pc_d          = br_target;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else begin
                    unique case (state_q)
                        FETCH: begin
                            wcnt_d  = WCNT_START;
                            state_d = WAIT;
                        end
                        WAIT: begin
                            if (wcnt_q == '0) begin
                                instr_d       = bus.mem_rdata;
                                instr_pc_d    = pc_q;
                                instr_valid_d = 1'b1;
                                state_d       = HOLD;
                            end else begin
                                wcnt_d = wcnt_q - 1'b1;
                            end
                        end
                        HOLD: begin
                            if (instr_valid_q && bus.instr_ready) begin
                                instr_valid_d = 1'b0;
                                pc_d          = pc_q + 1'b1;   // wraps at 2^PC_W
                                state_d       = FETCH;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            HALTED: ;   // sticky until reset, every input ignored

            default: begin
                // Unused encodings restart the fetch sequence cleanly.
                instr_valid_d = 1'b0;
                state_d       = LOAD;
            end
        endcase
    end

    // State, program counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            pc_q          <= '0;
            wcnt_q        <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            pc_q          <= pc_d;
            wcnt_q        <= wcnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // One read request per fetch, always addressed by the current pc.
    assign bus.mem_rd      = (state_q == FETCH);
    assign bus.mem_addr    = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign halted          = halted_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Two instances run side by side on
// shared stimulus: one with a 1-cycle memory, one with a 3-cycle memory.
// Each sees a pipelined ROM returning 16'hA000|addr for real requests and
// 16'hDEAD for cycles that carried no request.
module tb_fetch_unit;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] word_t;

    // Observed DUT outputs.
    typedef struct {
        logic  valid;
        word_t instr;
        pc_t   ipc;
        logic  mem_rd;
        pc_t   addr;
        logic  halted;
    } obs_t;

    // One table row: inputs for the next edge and outputs expected now.
    typedef struct {
        logic  rdy;
        logic  br;
        pc_t   tgt;
        logic  hlt;
        logic  e_valid;
        word_t e_instr;
        pc_t   e_ipc;
        logic  e_rd;
        pc_t   e_addr;
        logic  e_halted;
    } vec_t;

    // Reference model: a word appears a fixed number of edges after a fetch
    // begins; the countdown is the only notion of progress it keeps.
    typedef struct {
        bit    loading;
        bit    halted;
        bit    valid;
        int    busy;
        pc_t   pc;
        pc_t   ipc;
        word_t ins;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n;
    pc_t   start_pc;
    logic  ready;
    logic  br_taken;
    pc_t   br_target;
    logic  halt_req;
    logic  halted1, halted3;

    int checks = 0;
    int errors = 0;
    model_t mdl[2];

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus1 ();
    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus3 ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc), .br_taken(br_taken),
        .br_target(br_target), .halt_req(halt_req), .halted(halted1), .bus(bus1)
    );

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc), .br_taken(br_taken),
        .br_target(br_target), .halt_req(halt_req), .halted(halted3), .bus(bus3)
    );

    function automatic word_t rom_word(pc_t a);
        return 16'hA000 | INSTR_W'(a);
    endfunction

    // Pipelined ROMs, MEM_LAT stages deep, tagged with request presence.
    bit  p1_v;
    pc_t p1_a;
    bit  p3_v[3];
    pc_t p3_a[3];

    always @(posedge clk) begin
        p1_v    <= bus1.mem_rd;
        p1_a    <= bus1.mem_addr;
        p3_v[0] <= bus3.mem_rd;
        p3_a[0] <= bus3.mem_addr;
        for (int s = 1; s < 3; s++) begin
            p3_v[s] <= p3_v[s-1];
            p3_a[s] <= p3_a[s-1];
        end
    end

    assign bus1.mem_rdata   = p1_v    ? rom_word(p1_a)    : 16'hDEAD;
    assign bus3.mem_rdata   = p3_v[2] ? rom_word(p3_a[2]) : 16'hDEAD;
    assign bus1.instr_ready = ready;
    assign bus3.instr_ready = ready;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample(int i);
        obs_t o;
        if (i == 0) begin
            o.valid = bus1.instr_valid; o.instr = bus1.instr; o.ipc = bus1.instr_pc;
            o.mem_rd = bus1.mem_rd; o.addr = bus1.mem_addr; o.halted = halted1;
        end else begin
            o.valid = bus3.instr_valid; o.instr = bus3.instr; o.ipc = bus3.instr_pc;
            o.mem_rd = bus3.mem_rd; o.addr = bus3.mem_addr; o.halted = halted3;
        end
        return o;
    endfunction

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void model_reset(int i);
        mdl[i].loading = 1'b1;
        mdl[i].halted  = 1'b0;
        mdl[i].valid   = 1'b0;
        mdl[i].busy    = 0;
        mdl[i].pc      = '0;
        mdl[i].ipc     = '0;
        mdl[i].ins     = '0;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    function automatic void model_step(int i, logic rdy, logic br, pc_t tgt,
                                       logic hlt, pc_t spc);
        model_t m    = mdl[i];
        int     fill = lat_of(i) + 1;   // edges from entering a fetch to the word
        if (m.halted) begin
            // nothing moves
        end else if (m.loading) begin
            m.loading = 1'b0;
            m.pc      = spc;
            m.busy    = fill;
        end else if (hlt) begin
            m.halted = 1'b1;
            m.valid  = 1'b0;
        end else if (br) begin
            m.pc    = tgt;
            m.valid = 1'b0;
            m.busy  = fill;
        end else if (m.valid) begin
            if (rdy) begin
                m.valid = 1'b0;
                m.pc    = m.pc + 8'd1;
                m.busy  = fill;
            end
        end else begin
            m.busy--;
            if (m.busy == 0) begin
                m.valid = 1'b1;
                m.ins   = rom_word(m.pc);
                m.ipc   = m.pc;
            end
        end
        mdl[i] = m;
    endfunction

    task automatic model_check(int i, string tag);
        obs_t   o = sample(i);
        model_t m = mdl[i];
        logic   e_rd = !m.loading && !m.halted && !m.valid && (m.busy == lat_of(i) + 1);
        check({tag, "_valid"},  o.valid,  m.valid);
        check({tag, "_mem_rd"}, o.mem_rd, e_rd);
        check({tag, "_addr"},   o.addr,   m.pc);
        check({tag, "_halted"}, o.halted, m.halted);
        check({tag, "_instr"},  o.instr,  m.ins);
        check({tag, "_ipc"},    o.ipc,    m.ipc);
    endtask

    // Reset pulse; returns on the falling edge right after release, so the
    // next rising edge is edge 1.
    task automatic do_reset(pc_t spc);
        @(negedge clk);
        rst_n = 1'b0; ready = 1'b0; br_taken = 1'b0; halt_req = 1'b0;
        br_target = '0; start_pc = spc;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(0);
        model_reset(1);
    endtask

    // Counts rising edges until instr_valid is seen high.
    task automatic wait_valid(int i, string tag, output int edges, output obs_t o);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            o = sample(i);
        end while (o.valid !== 1'b1 && edges < 40);
        check({tag, "_valid_seen"}, o.valid, 1'b1);
    endtask

    vec_t tbl[13];

    initial begin
        int   e;
        int   rd_seen;
        obs_t o;

        rst_n = 1'b0; start_pc = '0; ready = 1'b0; br_taken = 1'b0;
        br_target = '0; halt_req = 1'b0;

        // Redirect during WAIT of fetch @05, then halt together with branch.
        //            rdy br  tgt    hlt  valid instr     ipc    rd  addr   hlt
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h04, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h04, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'hA004, 8'h04, 1'b0, 8'h04, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA004, 8'h04, 1'b1, 8'h05, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 16'hA004, 8'h04, 1'b0, 8'h05, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA004, 8'h04, 1'b1, 8'h40, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA004, 8'h04, 1'b0, 8'h40, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'hA040, 8'h40, 1'b0, 8'h40, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA040, 8'h40, 1'b1, 8'h41, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 16'hA040, 8'h40, 1'b0, 8'h41, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 16'hA040, 8'h40, 1'b0, 8'h41, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA040, 8'h40, 1'b0, 8'h41, 1'b1};

        // T1: steady stream from 04 with ready held high.
        do_reset(8'h04);
        ready = 1'b1;
        wait_valid(0, "t1a", e, o);
        check("t1_first_edge", e, 3);
        check("t1_instr0", o.instr, 16'hA004);
        check("t1_ipc0", o.ipc, 8'h04);
        wait_valid(0, "t1b", e, o);
        check("t1_gap1", e, 3);
        check("t1_instr1", o.instr, 16'hA005);
        wait_valid(0, "t1c", e, o);
        check("t1_gap2", e, 3);
        check("t1_instr2", o.instr, 16'hA006);

        // T2: decoder stalls for five cycles, word and valid must hold.
        do_reset(8'h04);
        wait_valid(0, "t2a", e, o);
        repeat (5) begin
            @(negedge clk);
            o = sample(0);
            check("t2_hold_valid", o.valid, 1'b1);
            check("t2_hold_instr", o.instr, 16'hA004);
            check("t2_hold_mem_rd", o.mem_rd, 1'b0);
        end
        ready = 1'b1;
        wait_valid(0, "t2b", e, o);
        check("t2_next_instr", o.instr, 16'hA005);
        check("t2_next_ipc", o.ipc, 8'h05);

        // T3: pc wraps from FF to 00.
        do_reset(8'hFF);
        ready = 1'b1;
        wait_valid(0, "t3a", e, o);
        check("t3_instr_ff", o.instr, 16'hA0FF);
        check("t3_ipc_ff", o.ipc, 8'hFF);
        wait_valid(0, "t3b", e, o);
        check("t3_instr_00", o.instr, 16'hA000);
        check("t3_ipc_00", o.ipc, 8'h00);

        // T4/T5 table: redirect mid-WAIT, then halt beating a branch.
        do_reset(8'h04);
        for (int n = 0; n < 13; n++) begin
            o = sample(0);
            check($sformatf("tbl%0d_valid", n),  o.valid,  tbl[n].e_valid);
            check($sformatf("tbl%0d_instr", n),  o.instr,  tbl[n].e_instr);
            check($sformatf("tbl%0d_ipc", n),    o.ipc,    tbl[n].e_ipc);
            check($sformatf("tbl%0d_mem_rd", n), o.mem_rd, tbl[n].e_rd);
            check($sformatf("tbl%0d_addr", n),   o.addr,   tbl[n].e_addr);
            check($sformatf("tbl%0d_halted", n), o.halted, tbl[n].e_halted);
            ready = tbl[n].rdy; br_taken = tbl[n].br;
            br_target = tbl[n].tgt; halt_req = tbl[n].hlt;
            @(negedge clk);
        end

        // T5: halted ignores everything for 20 cycles; reset restarts it.
        rd_seen = 0;
        repeat (20) begin
            ready = 1'($urandom); br_taken = 1'($urandom);
            halt_req = 1'($urandom); br_target = pc_t'($urandom);
            @(negedge clk);
            o = sample(0);
            if (o.mem_rd) rd_seen++;
            check("t5_halted", o.halted, 1'b1);
            check("t5_valid", o.valid, 1'b0);
        end
        check("t5_no_mem_rd", rd_seen, 0);
        do_reset(8'h04);
        o = sample(0);
        check("t5_reset_halted", o.halted, 1'b0);
        ready = 1'b1;
        wait_valid(0, "t5r", e, o);
        check("t5_restart_edge", e, 3);
        check("t5_restart_instr", o.instr, 16'hA004);

        // T6: 3-cycle memory, then async reset in the middle of WAIT.
        do_reset(8'h10);
        wait_valid(1, "t6a", e, o);
        check("t6_first_edge", e, 5);
        check("t6_instr", o.instr, 16'hA010);
        check("t6_ipc", o.ipc, 8'h10);
        ready = 1'b1;
        @(negedge clk);           // handshake edge: now in FETCH @11
        ready = 1'b0;
        @(negedge clk);           // now in WAIT
        #2 rst_n = 1'b0;
        #1 o = sample(1);
        check("t6_rst_valid", o.valid, 1'b0);
        check("t6_rst_instr", o.instr, 16'h0000);
        check("t6_rst_ipc", o.ipc, 8'h00);
        check("t6_rst_mem_rd", o.mem_rd, 1'b0);
        check("t6_rst_addr", o.addr, 8'h00);
        check("t6_rst_halted", o.halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(1, "t6b", e, o);
        check("t6_restart_edge", e, 5);
        check("t6_restart_instr", o.instr, 16'hA010);

        // Random traffic on both latencies against the reference model.
        for (int r = 0; r < 4; r++) begin
            do_reset(pc_t'($urandom));
            for (int c = 0; c < 400; c++) begin
                model_check(0, "rnd_l1");
                model_check(1, "rnd_l3");
                ready     = ($urandom_range(0, 9) < 7);
                br_taken  = ($urandom_range(0, 19) == 0);
                br_target = pc_t'($urandom);
                halt_req  = ($urandom_range(0, 299) == 0);
                model_step(0, ready, br_taken, br_target, halt_req, start_pc);
                model_step(1, ready, br_taken, br_target, halt_req, start_pc);
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound in case something upstream never returns.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_unit
